// File: rtl/v_decode_queue.sv
// Buffered, pipelined RVV decoder: instruction FIFO, combinational decode of the head and a
// registered uop bundle behind valid/ready. Optional macro V_DEC_ILLEGAL_EN adds an illegal flag.
module v_decode_queue #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned INSTR_W    = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [INSTR_W-1:0]            instr,
    input  logic                          instr_valid,
    output logic                          instr_ready,
    output logic                          uop_valid,
    input  logic                          uop_ready,
    input  logic                          cfg_done,
    output logic                          is_vconfig,
    output logic [3:0]                    v_alu_op,
    output logic                          is_mul,
    output logic [2:0]                    v_red_op,
    output logic [2:0]                    v_sldu_op,
    output logic [3:0]                    v_lsu_op,
    output logic                          is_vstype,
    output logic [1:0]                    v_op_sel_A,
    output logic [1:0]                    v_op_sel_B,
    output logic [1:0]                    v_sel_dest,
    output logic [4:0]                    vd,
    output logic [4:0]                    vs1,
    output logic [4:0]                    vs2,
    output logic [4:0]                    imm,
    output logic [10:0]                   zimm,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          cfg_busy
`ifdef V_DEC_ILLEGAL_EN
    ,
    output logic                          illegal
`endif
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    localparam logic [6:0] OPC_RTYPE = 7'b1010111;
    localparam logic [6:0] OPC_LTYPE = 7'b0000111;
    localparam logic [6:0] OPC_STYPE = 7'b0100111;

    localparam logic [2:0] OPI_VV = 3'b000;
    localparam logic [2:0] OPM_VV = 3'b010;
    localparam logic [2:0] OPI_VI = 3'b011;
    localparam logic [2:0] OPI_VX = 3'b100;
    localparam logic [2:0] OPM_VX = 3'b110;
    localparam logic [2:0] OP_SET = 3'b111;

    localparam logic [5:0] F6_VADD   = 6'b000000;
    localparam logic [5:0] F6_VSUB   = 6'b000010;
    localparam logic [5:0] F6_VMIN   = 6'b000101;
    localparam logic [5:0] F6_VMAX   = 6'b000111;
    localparam logic [5:0] F6_VAND   = 6'b001001;
    localparam logic [5:0] F6_VOR    = 6'b001010;
    localparam logic [5:0] F6_VXOR   = 6'b001011;
    localparam logic [5:0] F6_VSLUP  = 6'b001110;
    localparam logic [5:0] F6_VSLDN  = 6'b001111;
    localparam logic [5:0] F6_VMV    = 6'b010111;
    localparam logic [5:0] F6_VSLL   = 6'b100101;
    localparam logic [5:0] F6_VSRL   = 6'b101000;
    localparam logic [5:0] F6_VSRA   = 6'b101001;
    localparam logic [5:0] F6_VMUL   = 6'b100101;
    localparam logic [5:0] F6_REDSUM = 6'b000000;
    localparam logic [5:0] F6_REDMAX = 6'b000111;

    typedef enum logic [1:0] {StRun, StCfgWait, StIllHalt} state_e;

    typedef struct packed {
        logic        is_vconfig;
        logic [3:0]  alu_op;
        logic        is_mul;
        logic [2:0]  red_op;
        logic [2:0]  sldu_op;
        logic [3:0]  lsu_op;
        logic        is_vstype;
        logic [1:0]  sel_a;
        logic [1:0]  sel_b;
        logic [1:0]  sel_dest;
        logic [4:0]  vd;
        logic [4:0]  vs1;
        logic [4:0]  vs2;
        logic [4:0]  imm;
        logic [10:0] zimm;
    } uop_t;

    logic [INSTR_W-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]    count_q, count_d;
    state_e             state_q, state_d;
    logic               uop_valid_q, uop_valid_d;
    uop_t               uop_q, dec;
    logic               known, push, load, full, empty;
    logic [INSTR_W-1:0] head;
    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic [5:0]         funct6;
    logic               lsu_w_ok, mop_unit, mop_strided, is_store;
    logic [1:0]         lsu_w;

    assign full        = (count_q == CntW'(FIFO_DEPTH));
    assign empty       = (count_q == '0);
    assign instr_ready = !full && !flush;
    assign push        = instr_valid && instr_ready;
    assign load        = !flush && (state_q == StRun) && !empty && (!uop_valid_q || uop_ready);

    assign head        = mem_q[rd_ptr_q];
    assign opcode      = head[6:0];
    assign funct3      = head[14:12];
    assign funct6      = head[31:26];
    assign mop_unit    = (head[27:26] == 2'b00) && (head[24:20] == 5'd0);
    assign mop_strided = (head[27:26] == 2'b10);
    assign is_store    = (opcode == OPC_STYPE);

    always_comb begin
        lsu_w_ok = 1'b0;
        lsu_w    = 2'd0;
        case (funct3)
            3'b000:  begin lsu_w_ok = 1'b1; lsu_w = 2'd0; end
            3'b101:  begin lsu_w_ok = 1'b1; lsu_w = 2'd1; end
            3'b110:  begin lsu_w_ok = 1'b1; lsu_w = 2'd2; end
            default: ;
        endcase
    end

    always_comb begin
        dec   = '0;
        known = 1'b0;
        case (opcode)
            OPC_RTYPE: begin
                if (funct3 == OP_SET) begin
                    known          = 1'b1;
                    dec.is_vconfig = 1'b1;
                    dec.sel_dest   = 2'd2;
                    // vsetvli: rs1/zimm, vsetvl: rs1/rs2, vsetivli: uimm/zimm
                    case (head[31:30])
                        2'b11:   begin dec.sel_a = 2'd3; dec.sel_b = 2'd3; end
                        2'b10:   begin dec.sel_a = 2'd2; dec.sel_b = 2'd2; end
                        default: begin dec.sel_a = 2'd2; dec.sel_b = 2'd3; end
                    endcase
                end else begin
                    case (funct3)
                        OPI_VV, OPI_VX, OPI_VI: begin
                            case (funct6)
                                F6_VADD: dec.alu_op = 4'd1;
                                F6_VSUB: if (funct3 != OPI_VI) dec.alu_op = 4'd2;
                                F6_VAND: dec.alu_op = 4'd3;
                                F6_VOR:  dec.alu_op = 4'd4;
                                F6_VXOR: dec.alu_op = 4'd5;
                                F6_VSLL: dec.alu_op = 4'd6;
                                F6_VSRL: dec.alu_op = 4'd7;
                                F6_VSRA: dec.alu_op = 4'd8;
                                F6_VMIN: if (funct3 != OPI_VI) dec.alu_op = 4'd9;
                                F6_VMAX: if (funct3 != OPI_VI) dec.alu_op = 4'd10;
                                F6_VSLUP: if (funct3 != OPI_VV) dec.sldu_op = 3'd1;
                                F6_VSLDN: if (funct3 != OPI_VV) dec.sldu_op = 3'd2;
                                // vm=0 here is vmerge, which the slide unit does not handle
                                F6_VMV:  if (head[25]) dec.sldu_op = 3'd5;
                                default: ;
                            endcase
                        end
                        OPM_VV, OPM_VX: begin
                            case (funct6)
                                F6_VMUL:   dec.is_mul = 1'b1;
                                F6_REDSUM: if (funct3 == OPM_VV) dec.red_op = 3'd1;
                                F6_REDMAX: if (funct3 == OPM_VV) dec.red_op = 3'd2;
                                F6_VSLUP:  if (funct3 == OPM_VX) dec.sldu_op = 3'd3;
                                F6_VSLDN:  if (funct3 == OPM_VX) dec.sldu_op = 3'd4;
                                default: ;
                            endcase
                        end
                        default: ;
                    endcase
                    known = |{dec.alu_op, dec.is_mul, dec.red_op, dec.sldu_op};
                    case (funct3)
                        OPI_VV, OPM_VV: dec.sel_a = 2'd1;
                        OPI_VX, OPM_VX: dec.sel_a = 2'd2;
                        OPI_VI:         dec.sel_a = 2'd3;
                        default:        dec.sel_a = 2'd0;
                    endcase
                    dec.sel_b    = 2'd1;
                    dec.sel_dest = 2'd1;
                end
            end
            OPC_LTYPE, OPC_STYPE: begin
                if (lsu_w_ok && (head[31:28] == 4'd0) && (mop_unit || mop_strided)) begin
                    known         = 1'b1;
                    dec.is_vstype = is_store;
                    dec.lsu_op    = 4'd1 + {2'b00, lsu_w} + (mop_strided ? 4'd3 : 4'd0)
                                    + (is_store ? 4'd6 : 4'd0);
                    dec.sel_a     = 2'd2;
                    dec.sel_b     = mop_strided ? 2'd2 : 2'd0;
                    dec.sel_dest  = is_store ? 2'd0 : 2'd1;
                end
            end
            default: ;
        endcase
        if (!known) begin
            dec = '0;
        end else begin
            dec.vd   = head[11:7];
            dec.vs1  = head[19:15];
            dec.vs2  = head[24:20];
            dec.imm  = head[19:15];
            dec.zimm = head[30:20];
        end
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        uop_valid_d = uop_valid_q;
        state_d     = state_q;
        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            uop_valid_d = 1'b0;
            state_d     = StRun;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (load) rd_ptr_d = rd_ptr_q + PtrW'(1);
            case ({push, load})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
            if (load)           uop_valid_d = 1'b1;
            else if (uop_ready) uop_valid_d = 1'b0;
            unique case (state_q)
                StRun: begin
                    if (load) begin
                        if (dec.is_vconfig) state_d = StCfgWait;
`ifdef V_DEC_ILLEGAL_EN
                        else if (!known) state_d = StIllHalt;
`endif
                    end
                end
                StCfgWait: if (cfg_done) state_d = StRun;
                StIllHalt: state_d = StIllHalt;
                default:   state_d = StRun;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= instr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= StRun;
            uop_valid_q <= 1'b0;
            uop_q       <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            uop_valid_q <= uop_valid_d;
            if (load) uop_q <= dec;
        end
    end

`ifdef V_DEC_ILLEGAL_EN
    logic illegal_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else if (load) begin
            illegal_q <= !known;
        end
    end
    assign illegal = illegal_q;
`endif

    assign uop_valid  = uop_valid_q;
    assign is_vconfig = uop_q.is_vconfig;
    assign v_alu_op   = uop_q.alu_op;
    assign is_mul     = uop_q.is_mul;
    assign v_red_op   = uop_q.red_op;
    assign v_sldu_op  = uop_q.sldu_op;
    assign v_lsu_op   = uop_q.lsu_op;
    assign is_vstype  = uop_q.is_vstype;
    assign v_op_sel_A = uop_q.sel_a;
    assign v_op_sel_B = uop_q.sel_b;
    assign v_sel_dest = uop_q.sel_dest;
    assign vd         = uop_q.vd;
    assign vs1        = uop_q.vs1;
    assign vs2        = uop_q.vs2;
    assign imm        = uop_q.imm;
    assign zimm       = uop_q.zimm;
    assign fifo_count = count_q;
    assign cfg_busy   = (state_q == StCfgWait);

endmodule

// File: tb/tb_v_decode_queue.sv
// Randomised and directed bench for v_decode_queue against a queue-based reference model.
// Honours V_DEC_ILLEGAL_EN the same way as the design.
module tb_v_decode_queue;

    localparam int DEPTH  = 4;
    localparam int ST_RUN = 0;
    localparam int ST_CFG = 1;
    localparam int ST_ILL = 2;
`ifdef V_DEC_ILLEGAL_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    typedef struct packed {
        logic        vcfg;
        logic [3:0]  alu;
        logic        mul;
        logic [2:0]  red;
        logic [2:0]  sldu;
        logic [3:0]  lsu;
        logic        st;
        logic [1:0]  sa;
        logic [1:0]  sb;
        logic [1:0]  sd;
        logic [4:0]  vd;
        logic [4:0]  vs1;
        logic [4:0]  vs2;
        logic [4:0]  imm;
        logic [10:0] zimm;
    } exp_t;

    logic clk = 1'b0;
    logic rst, flush, instr_valid, uop_ready, cfg_done;
    logic [31:0] instr;
    logic instr_ready, uop_valid, is_vconfig, is_mul, is_vstype, cfg_busy;
    logic [3:0] v_alu_op, v_lsu_op;
    logic [2:0] v_red_op, v_sldu_op;
    logic [1:0] v_op_sel_A, v_op_sel_B, v_sel_dest;
    logic [4:0] vd, vs1, vs2, imm;
    logic [10:0] zimm;
    logic [2:0] fifo_count;
`ifdef V_DEC_ILLEGAL_EN
    logic illegal;
`endif

    v_decode_queue #(.FIFO_DEPTH(DEPTH), .INSTR_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .uop_valid(uop_valid), .uop_ready(uop_ready),
        .cfg_done(cfg_done), .is_vconfig(is_vconfig), .v_alu_op(v_alu_op), .is_mul(is_mul),
        .v_red_op(v_red_op), .v_sldu_op(v_sldu_op), .v_lsu_op(v_lsu_op),
        .is_vstype(is_vstype), .v_op_sel_A(v_op_sel_A), .v_op_sel_B(v_op_sel_B),
        .v_sel_dest(v_sel_dest), .vd(vd), .vs1(vs1), .vs2(vs2), .imm(imm), .zimm(zimm),
        .fifo_count(fifo_count), .cfg_busy(cfg_busy)
`ifdef V_DEC_ILLEGAL_EN
        , .illegal(illegal)
`endif
    );

    always #5 clk = ~clk;

    exp_t dut_bundle;
    assign dut_bundle = {is_vconfig, v_alu_op, is_mul, v_red_op, v_sldu_op, v_lsu_op, is_vstype,
                         v_op_sel_A, v_op_sel_B, v_sel_dest, vd, vs1, vs2, imm, zimm};

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Decode table for the OP-V arithmetic space: funct6, allowed-funct3 bitmask, unit, code
    // unit: 0 alu, 1 mul, 2 red, 3 sldu. Row 17 (vmv) additionally requires vm=1.
    int t_f6[18], t_f3m[18], t_unit[18], t_code[18];

    task automatic set_row(input int r, input int f6, input int m, input int u, input int c);
        t_f6[r] = f6; t_f3m[r] = m; t_unit[r] = u; t_code[r] = c;
    endtask

    task automatic fill_table();
        set_row(0, 'b000000, 'h19, 0, 1);  set_row(1, 'b000010, 'h11, 0, 2);
        set_row(2, 'b001001, 'h19, 0, 3);  set_row(3, 'b001010, 'h19, 0, 4);
        set_row(4, 'b001011, 'h19, 0, 5);  set_row(5, 'b100101, 'h19, 0, 6);
        set_row(6, 'b101000, 'h19, 0, 7);  set_row(7, 'b101001, 'h19, 0, 8);
        set_row(8, 'b000101, 'h11, 0, 9);  set_row(9, 'b000111, 'h11, 0, 10);
        set_row(10, 'b100101, 'h44, 1, 1); set_row(11, 'b000000, 'h04, 2, 1);
        set_row(12, 'b000111, 'h04, 2, 2); set_row(13, 'b001110, 'h18, 3, 1);
        set_row(14, 'b001111, 'h18, 3, 2); set_row(15, 'b001110, 'h40, 3, 3);
        set_row(16, 'b001111, 'h40, 3, 4); set_row(17, 'b010111, 'h19, 3, 5);
    endtask

    function automatic exp_t ref_decode(input logic [31:0] i, output bit ill);
        exp_t e = '0;
        bit known = 1'b0;
        int f3 = int'(i[14:12]);
        int f6 = int'(i[31:26]);
        int w;
        bit strided, unit, store;
        if (i[6:0] == 7'h57 && f3 == 7) begin
            known = 1'b1; e.vcfg = 1'b1; e.sd = 2'd2;
            if (i[31:30] == 2'b11)      begin e.sa = 2'd3; e.sb = 2'd3; end
            else if (i[31:30] == 2'b10) begin e.sa = 2'd2; e.sb = 2'd2; end
            else                        begin e.sa = 2'd2; e.sb = 2'd3; end
        end else if (i[6:0] == 7'h57) begin
            for (int r = 0; r < 18; r++) begin
                if (t_f6[r] == f6 && t_f3m[r][f3] && (r != 17 || i[25])) begin
                    known = 1'b1;
                    case (t_unit[r])
                        0: e.alu = 4'(t_code[r]);
                        1: e.mul = 1'b1;
                        2: e.red = 3'(t_code[r]);
                        default: e.sldu = 3'(t_code[r]);
                    endcase
                end
            end
            if (known) begin
                e.sa = (f3 == 0 || f3 == 2) ? 2'd1 : (f3 == 3) ? 2'd3 : 2'd2;
                e.sb = 2'd1; e.sd = 2'd1;
            end
        end else if (i[6:0] == 7'h07 || i[6:0] == 7'h27) begin
            w = (f3 == 0) ? 0 : (f3 == 5) ? 1 : (f3 == 6) ? 2 : -1;
            strided = (i[27:26] == 2'b10);
            unit = (i[27:26] == 2'b00) && (i[24:20] == 5'd0);
            store = (i[6:0] == 7'h27);
            if (w >= 0 && i[31:28] == 4'd0 && (strided || unit)) begin
                known = 1'b1;
                e.lsu = 4'(1 + w + 3 * int'(strided) + 6 * int'(store));
                e.st = store; e.sa = 2'd2; e.sb = strided ? 2'd2 : 2'd0;
                e.sd = store ? 2'd0 : 2'd1;
            end
        end
        if (known) begin
            e.vd = i[11:7]; e.vs1 = i[19:15]; e.vs2 = i[24:20]; e.imm = i[19:15];
            e.zimm = i[30:20];
        end
        ill = !known;
        return e;
    endfunction

    // Reference model state: pending instructions, output bundle, issue state
    logic [31:0] mq[$];
    bit   m_ov;
    int   m_st;
    exp_t m_ob;
    bit   m_ill;

    task automatic model_reset();
        mq.delete(); m_ov = 1'b0; m_st = ST_RUN; m_ob = '0; m_ill = 1'b0;
    endtask

    task automatic model_step();
        bit ld, pu, ill;
        exp_t e;
        if (flush) begin
            mq.delete(); m_ov = 1'b0; m_st = ST_RUN;
            return;
        end
        ld = (m_st == ST_RUN) && (mq.size() > 0) && (!m_ov || uop_ready);
        pu = instr_valid && (mq.size() < DEPTH);
        if (ld) begin
            e = ref_decode(mq.pop_front(), ill);
            m_ob = e; m_ill = ill; m_ov = 1'b1;
            if (e.vcfg) m_st = ST_CFG;
            else if (ill && ILL_EN) m_st = ST_ILL;
        end else begin
            if (uop_ready) m_ov = 1'b0;
            if (m_st == ST_CFG && cfg_done) m_st = ST_RUN;
        end
        if (pu) mq.push_back(instr);
    endtask

    task automatic compare();
        check("instr_ready", instr_ready, (mq.size() < DEPTH) && !flush);
        check("uop_valid", uop_valid, m_ov);
        check("fifo_count", fifo_count, mq.size());
        check("cfg_busy", cfg_busy, m_st == ST_CFG);
        check("bundle", dut_bundle, m_ob);
`ifdef V_DEC_ILLEGAL_EN
        check("illegal", illegal, m_ill);
`endif
    endtask

    task automatic step();
        @(negedge clk);
        compare();
        @(posedge clk);
        if (!rst) model_step();
        #1;
    endtask

    task automatic drive(input bit v, input logic [31:0] i, input bit r, input bit f, input bit c);
        instr_valid = v; instr = i; uop_ready = r; flush = f; cfg_done = c;
    endtask

    function automatic logic [31:0] mk_vadd(input logic [4:0] d);
        return {6'b000000, 1'b1, 5'd2, 5'd1, 3'b000, d, 7'h57};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r = $urandom;
        int k = $urandom_range(0, 11);
        int row = $urandom_range(0, 17);
        int fsel = t_f6[row];
        logic [5:0] f6 = fsel[5:0];
        logic [2:0] f3 = 3'($urandom_range(0, 6));
        logic [2:0] w;
        logic [1:0] mop = 2'($urandom_range(0, 3));
        logic [4:0] lumop = ($urandom_range(0, 3) == 0) ? r[24:20] : 5'd0;
        logic [3:0] top = ($urandom_range(0, 5) == 0) ? r[31:28] : 4'd0;
        case ($urandom_range(0, 3))
            0: w = 3'b000;
            1: w = 3'b101;
            2: w = 3'b110;
            default: w = 3'b111;
        endcase
        if ($urandom_range(0, 7) == 0) f6 = r[31:26];
        if (k <= 5) return {f6, r[25:15], f3, r[11:7], 7'h57};
        if (k <= 7) return {top, mop, r[25], lumop, r[19:15], w, r[11:7],
                            (k == 6) ? 7'h07 : 7'h27};
        if (k == 8) return {r[31:15], 3'b111, r[11:7], 7'h57};
        if (k == 9) return r;
        if (k == 10) return 32'h0000_0013;
        return mk_vadd(r[11:7]);
    endfunction

    initial begin
        fill_table();
        rst = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        model_reset();
        #12;
        check("rst_instr_ready", instr_ready, 1);
        check("rst_uop_valid", uop_valid, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_cfg_busy", cfg_busy, 0);
        check("rst_bundle", dut_bundle, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // vadd.vv into an empty queue: valid two cycles after presentation
        drive(1'b1, 32'h022081D7, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("t1_not_yet", uop_valid, 0);
        step();
        check("t1_valid", uop_valid, 1);
        check("t1_alu", v_alu_op, 1);
        check("t1_selA", v_op_sel_A, 1);
        check("t1_selB", v_op_sel_B, 1);
        check("t1_regs", {vd, vs1, vs2}, {5'd3, 5'd1, 5'd2});
        step();
        check("t1_drop", uop_valid, 0);

        // Back-pressure: five accepted (one in the output register, four queued)
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, mk_vadd(5'(10 + k)), 1'b0, 1'b0, 1'b0);
            step();
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("t2_full_ready", instr_ready, 0);
        check("t2_full_count", fifo_count, 4);
        repeat (3) step();
        check("t2_held", vd, 10);
        uop_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("t2_order_valid", uop_valid, 1);
            check("t2_order_vd", vd, 10 + k);
            step();
        end
        check("t2_empty", uop_valid, 0);

        // vsetvli serialises the following vadd until cfg_done
        drive(1'b1, 32'h0D0572D7, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b1, mk_vadd(5'd7), 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("t3_busy", cfg_busy, 1);
        check("t3_vcfg", is_vconfig, 1);
        check("t3_dest", v_sel_dest, 2);
        repeat (3) step();
        check("t3_blocked", uop_valid, 0);
        check("t3_queued", fifo_count, 1);
        cfg_done = 1'b1;
        step();
        cfg_done = 1'b0;
        check("t3_unbusy", cfg_busy, 0);
        step();
        check("t3_vadd", {uop_valid, v_alu_op, vd}, {1'b1, 4'd1, 5'd7});
        step();

        // cfg_done coincident with the vconfig load is ignored
        drive(1'b1, 32'h0D0572D7, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b0, '0, 1'b1, 1'b0, 1'b1);
        step();
        cfg_done = 1'b0;
        check("t3b_busy", cfg_busy, 1);
        step();
        check("t3b_still", cfg_busy, 1);
        cfg_done = 1'b1;
        step();
        cfg_done = 1'b0;
        check("t3b_release", cfg_busy, 0);

        // Flush with three queued and a valid bundle; the offered instr is dropped
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, mk_vadd(5'(20 + k)), 1'b0, 1'b0, 1'b0);
            step();
        end
        check("t4_pre_count", fifo_count, 3);
        check("t4_pre_valid", uop_valid, 1);
        drive(1'b1, mk_vadd(5'd30), 1'b0, 1'b1, 1'b0);
        #1;
        check("t4_ready_in_flush", instr_ready, 0);
        step();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        #1;
        check("t4_count", fifo_count, 0);
        check("t4_valid", uop_valid, 0);
        check("t4_ready", instr_ready, 1);
        step();

        // Saturated flow with wrap: occupancy settles and stays put
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, mk_vadd(5'(k)), 1'b0, 1'b0, 1'b0);
            step();
        end
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, mk_vadd(5'(6 + k)), 1'b1, 1'b0, 1'b0);
            step();
            if (k >= 1) check("t5_count", fifo_count, 3);
        end
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        repeat (6) step();

        // Unknown instruction: zero bundle, then halt or continue
        drive(1'b1, 32'h0000_0013, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b1, mk_vadd(5'd9), 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("t6_zero", {uop_valid, dut_bundle}, {1'b1, 54'd0});
`ifdef V_DEC_ILLEGAL_EN
        check("t6_illegal", illegal, 1);
        repeat (3) step();
        check("t6_halted", {uop_valid, fifo_count}, {1'b0, 3'd1});
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b1, mk_vadd(5'd9), 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step();
`else
        step();
`endif
        check("t6_next", {uop_valid, vd}, {1'b1, 5'd9});
        step();

        // Asynchronous reset mid-stream
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, mk_vadd(5'(k)), 1'b0, 1'b0, 1'b0);
            step();
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #2;
        check("t7_count", fifo_count, 0);
        check("t7_valid", uop_valid, 0);
        check("t7_ready", instr_ready, 1);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            drive($urandom_range(0, 9) < 7, rand_instr(), $urandom_range(0, 9) < 6,
                  $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 20);
            step();
        end
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
